// File: rtl/block_rasterizer_if.sv
// block_rasterizer_if: bundles the cell-request stream and the pixel stream
// of block_rasterizer.
//   master : the environment side (issues cell requests, accepts pixels)
//   slave  : the rasterizer side (accepts cell requests, issues pixels,
//            reports done/err)
interface block_rasterizer_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_col;
  logic [9:0]  req_row;
  logic [11:0] req_color;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [11:0] pix_color;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_col, req_row, req_color, pix_ready,
    input  req_ready, pix_valid, pix_x, pix_y, pix_color, done, err
  );

  modport slave (
    input  req_valid, req_col, req_row, req_color, pix_ready,
    output req_ready, pix_valid, pix_x, pix_y, pix_color, done, err
  );
endinterface

// File: rtl/block_rasterizer.sv
// block_rasterizer: expands one grid cell (col, row) into the row-major
// stream of BLOCK_SIDE x BLOCK_SIDE screen pixels it covers.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : block_rasterizer_if.slave
//          req_valid/req_ready/req_col/req_row/req_color : cell request
//          pix_valid/pix_ready/pix_x/pix_y/pix_color     : pixel stream
//          done (1-cycle pulse), err (qualifies done: cell out of range)
module block_rasterizer #(
  parameter int BLOCK_SIDE = 20,
  parameter int GRID_COLS  = 10,
  parameter int GRID_ROWS  = 20,
  parameter int X_OFFSET   = 0,
  parameter int Y_OFFSET   = 0
) (
  input  logic                clk,
  input  logic                rst,
  block_rasterizer_if.slave   bus
);

  localparam logic [9:0] SIDE = 10'(BLOCK_SIDE);
  localparam logic [9:0] LAST = 10'(BLOCK_SIDE - 1);
  localparam logic [9:0] XOFF = 10'(X_OFFSET);
  localparam logic [9:0] YOFF = 10'(Y_OFFSET);
  localparam logic [9:0] COLS = 10'(GRID_COLS);
  localparam logic [9:0] ROWS = 10'(GRID_ROWS);

  typedef enum logic [1:0] {IDLE, SETUP, EMIT, FIN} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  col_reg, col_next;
  logic [9:0]  row_reg, row_next;
  logic [11:0] color_reg, color_next;
  logic [9:0]  x0_reg, x0_next;
  logic [9:0]  y0_reg, y0_next;
  logic [9:0]  dx_reg, dx_next;
  logic [9:0]  dy_reg, dy_next;
  logic        err_reg, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      color_reg <= '0;
      x0_reg    <= '0;
      y0_reg    <= '0;
      dx_reg    <= '0;
      dy_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      color_reg <= color_next;
      x0_reg    <= x0_next;
      y0_reg    <= y0_next;
      dx_reg    <= dx_next;
      dy_reg    <= dy_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    color_next    = color_reg;
    x0_next       = x0_reg;
    y0_next       = y0_reg;
    dx_next       = dx_reg;
    dy_next       = dy_reg;
    err_next      = err_reg;
    bus.req_ready = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.pix_color = '0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;

    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          col_next   = bus.req_col;
          row_next   = bus.req_row;
          color_next = bus.req_color;
          state_next = SETUP;
        end
      end

      SETUP: begin
        // Cell origin; the constant multiply reduces to shift-add
        // ((i<<4)+(i<<2) for a side of 20). Everything wraps at 10 bits.
        x0_next = XOFF + col_reg * SIDE;
        y0_next = YOFF + row_reg * SIDE;
        dx_next = '0;
        dy_next = '0;
        if (col_reg >= COLS || row_reg >= ROWS) begin
          err_next   = 1'b1;
          state_next = FIN;
        end else begin
          state_next = EMIT;
        end
      end

      EMIT: begin
        // Outputs come only from registers, so they hold while stalled and
        // pix_valid never depends on pix_ready.
        bus.pix_valid = 1'b1;
        bus.pix_x     = x0_reg + dx_reg;
        bus.pix_y     = y0_reg + dy_reg;
        bus.pix_color = color_reg;
        if (bus.pix_ready) begin
          if (dx_reg == LAST) begin
            dx_next = '0;
            if (dy_reg == LAST) begin
              state_next = FIN;
            end else begin
              dy_next = dy_reg + 10'd1;
            end
          end else begin
            dx_next = dx_reg + 10'd1;
          end
        end
      end

      FIN: begin
        bus.done   = 1'b1;
        bus.err    = err_reg;
        err_next   = 1'b0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_rasterizer.sv
// Testbench for block_rasterizer. Two instances run in lockstep on the same
// stimulus: one with default offsets and one with X_OFFSET=100. Accepted
// pixels are compared against a reference computed directly from cell
// geometry (pixel k of a cell is at column k%SIDE, row k/SIDE).
module tb_block_rasterizer;

  localparam int SIDE = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [9:0]  req_col;
  logic [9:0]  req_row;
  logic [11:0] req_color;
  logic        pix_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  block_rasterizer_if bus0 ();
  block_rasterizer_if bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_col   = req_col;
  assign bus0.req_row   = req_row;
  assign bus0.req_color = req_color;
  assign bus0.pix_ready = pix_ready;
  assign bus1.req_valid = req_valid;
  assign bus1.req_col   = req_col;
  assign bus1.req_row   = req_row;
  assign bus1.req_color = req_color;
  assign bus1.pix_ready = pix_ready;

  block_rasterizer u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  block_rasterizer #(.X_OFFSET(100)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected packed {x, y, color} of the k-th pixel of a cell.
  function automatic logic [31:0] exp_pix(input int offx, input int col, input int row,
                                          input int k, input logic [11:0] color);
    int x;
    int y;
    x = offx + col * SIDE + (k % SIDE);
    y = row * SIDE + (k / SIDE);
    return {x[9:0], y[9:0], color};
  endfunction

  // One request from the IDLE cycle to the cycle after done (or to an
  // injected reset once abort_at pixels have been accepted).
  task automatic run_req(input logic [9:0] col, input logic [9:0] row, input logic [11:0] color,
                         input int ready_pct, input int abort_at, input bit queue_next,
                         input logic [9:0] ncol, input logic [9:0] nrow, input logic [11:0] ncolor);
    int n = 0;
    int cyc = 0;
    int done_cyc = -1;
    bit in_range;
    bit prev_stall = 0;
    logic [31:0] cur0, cur1, held0, held1;
    in_range = (col < 10) && (row < 20);

    req_valid = 1'b1;
    req_col   = col;
    req_row   = row;
    req_color = color;
    check("req_ready_idle", 32'(bus0.req_ready), 32'd1);
    step();
    cyc = 1;
    req_valid = 1'b0;
    check("setup_req_ready", 32'(bus0.req_ready), 32'd0);
    check("setup_pix_valid", 32'(bus0.pix_valid), 32'd0);

    while (cyc < 3000) begin
      step();
      cyc++;
      pix_ready = ($urandom_range(99) < 32'(ready_pct));
      if (queue_next && cyc == 50) begin
        req_valid = 1'b1;
        req_col   = ncol;
        req_row   = nrow;
        req_color = ncolor;
      end
      if (req_valid) check("busy_req_ready", 32'(bus0.req_ready), 32'd0);
      check("done_and_valid", 32'(bus0.done & bus0.pix_valid), 32'd0);
      check("pix_valid", 32'(bus0.pix_valid), 32'(in_range && n < SIDE * SIDE));
      cur0 = {bus0.pix_x, bus0.pix_y, bus0.pix_color};
      cur1 = {bus1.pix_x, bus1.pix_y, bus1.pix_color};
      if (prev_stall) begin
        check("hold0", cur0, held0);
        check("hold1", cur1, held1);
      end
      if (bus0.done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b1;
        pix_ready = 1'b0;
        step();
        rst = 1'b0;
        check("abort_pix_valid", 32'(bus0.pix_valid), 32'd0);
        check("abort_done", 32'(bus0.done), 32'd0);
        check("abort_req_ready", 32'(bus0.req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
          step();
          check("abort_no_done", 32'({bus0.done, bus1.done}), 32'd0);
        end
        $display("req col=%0d row=%0d aborted by rst after %0d pixels", col, row, n);
        return;
      end
      if (bus0.pix_valid) begin
        if (pix_ready) begin
          check("pix0", cur0, exp_pix(0, int'(col), int'(row), n, color));
          check("pix1", cur1, exp_pix(100, int'(col), int'(row), n, color));
          n++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          held0 = cur0;
          held1 = cur1;
        end
      end else begin
        prev_stall = 0;
      end
    end

    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    check("pix_count", 32'(n), in_range ? 32'd400 : 32'd0);
    if (ready_pct == 100) check("done_cycle", 32'(done_cyc), in_range ? 32'd402 : 32'd2);
    check("err0", 32'({bus0.done, bus0.err}), {30'd0, 1'b1, !in_range});
    check("err1", 32'({bus1.done, bus1.err}), {30'd0, 1'b1, !in_range});
    step();
    check("req_ready_after", 32'(bus0.req_ready), 32'd1);
    check("done_cleared", 32'(bus0.done), 32'd0);
    $display("req col=%0d row=%0d color=%h pixels=%0d done_cycle=%0d err=%0d",
             col, row, color, n, done_cyc, !in_range);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_col = '0;
    req_row = '0;
    req_color = '0;
    pix_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_pix_valid", 32'(bus0.pix_valid), 32'd0);
    check("rst_pix_xy", {12'd0, bus0.pix_x, bus0.pix_y}, 32'd0);
    check("rst_pix_color", 32'(bus0.pix_color), 32'd0);
    check("rst_done_err", 32'({bus0.done, bus0.err}), 32'd0);
    check("rst_req_ready", 32'(bus0.req_ready), 32'd1);

    run_req(10'd0, 10'd0, 12'hF00, 100, -1, 1'b0, 10'd0, 10'd0, 12'h000);
    run_req(10'd9, 10'd19, 12'hABC, 100, -1, 1'b0, 10'd0, 10'd0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      run_req(10'($urandom_range(9)), 10'($urandom_range(19)), 12'($urandom),
              50, -1, 1'b0, 10'd0, 10'd0, 12'h000);
    end
    run_req(10'd10, 10'd3, 12'h0F0, 100, -1, 1'b0, 10'd0, 10'd0, 12'h000);
    run_req(10'd2, 10'd5, 12'h0F0, 100, -1, 1'b1, 10'd4, 10'd7, 12'h00F);
    run_req(10'd4, 10'd7, 12'h00F, 60, -1, 1'b0, 10'd0, 10'd0, 12'h000);
    run_req(10'd3, 10'd4, 12'h123, 100, 57, 1'b0, 10'd0, 10'd0, 12'h000);
    run_req(10'd1, 10'd1, 12'h321, 100, -1, 1'b0, 10'd0, 10'd0, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
